// File: rtl/dmem_sized.sv
// Data memory for the single-cycle ARM datapath: sized byte/half/word access,
// fault detection and a post-reset sweep that zeroes the array before use.
module dmem_sized #(
  parameter int DEPTH          = 64,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic [1:0]  SIZE,
  input  logic        SIGNED,
  output logic [31:0] RD,
  output logic        BUSY,
  output logic        FAULT,
  output logic        FAULT_SEEN
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t      state, nextState;
  logic [AW:0] ptr;
  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic          outOfRange, misaligned, doStore;
  logic [3:0]    byteEn;
  logic [31:0]   wdata, word;
  logic [7:0]    byteSel;
  logic [15:0]   halfSel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR_ON_RESET ? CLEAR : READY;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (state == CLEAR && ptr == LAST) nextState = READY;
  end

  // ptr parks at DEPTH once the sweep ends, so it never wraps back into the array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ptr <= '0;
    else if (state == CLEAR) ptr <= ptr + 1'b1;
  end

  assign BUSY       = (state == CLEAR);
  assign idx        = A[AW+1:2];
  assign outOfRange = |A[31:AW+2];
  assign misaligned = (SIZE == 2'b01 && A[0]) || (SIZE == 2'b10 && A[1:0] != 2'b00);
  assign FAULT      = (state == READY) && (outOfRange || misaligned || SIZE == 2'b11);
  assign doStore    = (state == READY) && !FAULT && WE;

  always_comb begin
    byteEn = 4'b0000;
    wdata  = WD;
    case (SIZE)
      2'b00: begin
        byteEn = 4'b0001 << A[1:0];
        wdata  = {4{WD[7:0]}};
      end
      2'b01: begin
        byteEn = A[1] ? 4'b1100 : 4'b0011;
        wdata  = {2{WD[15:0]}};
      end
      2'b10: byteEn = 4'b1111;
      default: byteEn = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr[AW-1:0]] <= '0;
    end else if (doStore) begin
      for (int i = 0; i < 4; i++)
        if (byteEn[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Loads are combinational so the single-cycle core sees data in the same cycle
  always_comb begin
    word    = mem[idx];
    byteSel = word[{A[1:0], 3'b000} +: 8];
    halfSel = A[1] ? word[31:16] : word[15:0];
    RD      = '0;
    if (!BUSY && !FAULT) begin
      case (SIZE)
        2'b00:   RD = {{24{SIGNED & byteSel[7]}}, byteSel};
        2'b01:   RD = {{16{SIGNED & halfSel[15]}}, halfSel};
        default: RD = word;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     FAULT_SEEN <= 1'b0;
    else if (FAULT) FAULT_SEEN <= 1'b1;
  end

endmodule

// File: tb/tb_dmem_sized.sv
// Bench for dmem_sized: a DEPTH=8 and a DEPTH=64 instance share stimulus and are
// checked every cycle against a byte-addressed model plus directed literal checks.
module tb_dmem_sized;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, WD;
  logic        WE, SIGNED;
  logic [1:0]  SIZE;

  logic [31:0] rdV [2];
  logic [1:0]  busyV, faultV, seenV;

  int nChecks = 0;
  int nFails  = 0;

  // model state: one memory image, sweep countdown and sticky flag per instance
  int          dep [2] = '{8, 64};
  int          rem [2] = '{8, 64};
  logic [31:0] mdl [2][64];
  logic        fs  [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  dmem_sized #(.DEPTH(8), .CLEAR_ON_RESET(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(A), .WD(WD), .WE(WE), .SIZE(SIZE), .SIGNED(SIGNED),
    .RD(rdV[0]), .BUSY(busyV[0]), .FAULT(faultV[0]), .FAULT_SEEN(seenV[0])
  );

  dmem_sized #(.DEPTH(64), .CLEAR_ON_RESET(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .A(A), .WD(WD), .WE(WE), .SIZE(SIZE), .SIGNED(SIGNED),
    .RD(rdV[1]), .BUSY(busyV[1]), .FAULT(faultV[1]), .FAULT_SEEN(seenV[1])
  );

  function automatic logic expFault(input int k);
    if (rem[k] > 0) return 1'b0;
    return (A >= 32'(dep[k] * 4)) || (SIZE == 2'd3) ||
           (SIZE == 2'd1 && (A % 2) != 0) || (SIZE == 2'd2 && (A % 4) != 0);
  endfunction

  function automatic logic [31:0] expRd(input int k);
    logic [31:0] w, v;
    int off;
    if (rem[k] > 0 || expFault(k)) return 32'h0;
    off = int'(A % 4);
    w   = mdl[k][int'(A >> 2)];
    case (SIZE)
      2'd0: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (SIGNED && v[7]) v = v | 32'hFFFFFF00;
      end
      2'd1: begin
        v = (w >> (8 * off)) & 32'hFFFF;
        if (SIGNED && v[15]) v = v | 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // model update: sweep one word per edge, then byte-addressed stores
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        rem[k] <= dep[k];
        fs[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (rem[k] > 0) begin
          mdl[k][dep[k] - rem[k]] <= 32'h0;
          rem[k] <= rem[k] - 1;
        end else if (expFault(k)) begin
          fs[k] <= 1'b1;
        end else if (WE) begin
          for (int b = 0; b < 4; b++)
            if (b >= int'(A % 4) && b < int'(A % 4) + (1 << SIZE))
              mdl[k][int'(A >> 2)][8*b +: 8] <= 8'(WD >> (8 * (b - int'(A % 4))));
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("cyc dut%0d RD", k), rdV[k], expRd(k));
      checkOutput($sformatf("cyc dut%0d BUSY", k), 32'(busyV[k]), 32'(rem[k] > 0));
      checkOutput($sformatf("cyc dut%0d FAULT", k), 32'(faultV[k]), 32'(expFault(k)));
      checkOutput($sformatf("cyc dut%0d FAULT_SEEN", k), 32'(seenV[k]), 32'(fs[k]));
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic we,
                               input logic [1:0] sz, input logic sg);
    @(posedge clk);
    #1;
    A = a; WD = wd; WE = we; SIZE = sz; SIGNED = sg;
  endtask

  task automatic idle();
    applyStimulus(32'h0, 32'h0, 1'b0, 2'd2, 1'b0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic countBusy(input int k, input int bound, output int n);
    n = 0;
    while (busyV[k] && n < bound) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  // load then sample a short delay later, away from either clock edge
  task automatic load(input string name, input int k, input logic [31:0] a,
                      input logic [1:0] sz, input logic sg, input logic [31:0] expected);
    applyStimulus(a, 32'h0, 1'b0, sz, sg);
    #1 checkOutput(name, rdV[k], expected);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    A = 32'h0; WD = 32'h0; WE = 1'b0; SIZE = 2'd2; SIGNED = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset BUSY8", 32'(busyV[0]), 32'h1);
    checkOutput("reset RD8", rdV[0], 32'h0);
    rst_n = 1'b1;
    countBusy(0, 20, n);
    checkOutput("sweep8 edges", n, 8);
    countBusy(1, 100, n);
    checkOutput("sweep64 remaining edges", n, 56);

    // preload nonzero words, then a reset sweep must clear them
    for (int i = 0; i < 8; i++)
      applyStimulus(32'(i * 4), 32'hA5A50000 | 32'(i), 1'b1, 2'd2, 1'b0);
    load("preload 0x1C", 0, 32'h1C, 2'd2, 1'b0, 32'hA5A50007);
    idle();
    doReset();
    countBusy(0, 20, n);
    checkOutput("resweep8 edges", n, 8);
    for (int i = 0; i < 8; i++)
      load($sformatf("cleared 0x%02h", i * 4), 0, 32'(i * 4), 2'd2, 1'b0, 32'h0);

    // reset in the middle of the sweep restarts it
    idle();
    doReset();
    idle();
    idle();
    doReset();
    countBusy(0, 20, n);
    checkOutput("midreset sweep8 edges", n, 8);
    countBusy(1, 100, n);

    // access attempted during the sweep is ignored
    doReset();
    applyStimulus(32'h04, 32'hDEADBEEF, 1'b1, 2'd2, 1'b0);
    #1;
    checkOutput("busy RD", rdV[0], 32'h0);
    checkOutput("busy FAULT", 32'(faultV[0]), 32'h0);
    idle();
    countBusy(1, 100, n);
    checkOutput("busy done", 32'(busyV), 32'h0);
    load("busy word 0x04", 0, 32'h04, 2'd2, 1'b0, 32'h0);

    // byte lanes
    applyStimulus(32'h10, 32'h11223344, 1'b1, 2'd2, 1'b0);
    applyStimulus(32'h12, 32'h000000AA, 1'b1, 2'd0, 1'b0);
    load("word 0x10", 0, 32'h10, 2'd2, 1'b0, 32'h11AA3344);
    load("sbyte 0x12", 0, 32'h12, 2'd0, 1'b1, 32'hFFFFFFAA);
    load("ubyte 0x12", 1, 32'h12, 2'd0, 1'b0, 32'h000000AA);
    load("ubyte 0x13", 1, 32'h13, 2'd0, 1'b1, 32'h00000011);

    // halfwords
    applyStimulus(32'h14, 32'hCAFEBABE, 1'b1, 2'd2, 1'b0);
    applyStimulus(32'h16, 32'h00008001, 1'b1, 2'd1, 1'b0);
    load("shalf 0x16", 0, 32'h16, 2'd1, 1'b1, 32'hFFFF8001);
    load("uhalf 0x16", 1, 32'h16, 2'd1, 1'b0, 32'h00008001);
    load("word 0x14", 0, 32'h14, 2'd2, 1'b0, 32'h8001BABE);
    load("shalf 0x14", 1, 32'h14, 2'd1, 1'b1, 32'hFFFFBABE);

    // faults
    applyStimulus(32'h00, 32'h12345678, 1'b1, 2'd2, 1'b0);
    #1 checkOutput("no fault yet", 32'(seenV), 32'h0);
    applyStimulus(32'h102, 32'hFFFFFFFF, 1'b1, 2'd2, 1'b0);
    #1 checkOutput("fault 0x102", 32'(faultV[1]), 32'h1);
    applyStimulus(32'h100, 32'hFFFFFFFF, 1'b1, 2'd2, 1'b0);
    #1;
    checkOutput("seen after 0x102", 32'(seenV[1]), 32'h1);
    checkOutput("fault 0x100", 32'(faultV[1]), 32'h1);
    applyStimulus(32'h08, 32'h0, 1'b0, 2'd3, 1'b0);
    #1 checkOutput("fault size11", 32'(faultV[1]), 32'h1);
    applyStimulus(32'h21, 32'hFFFF, 1'b1, 2'd1, 1'b0);
    #1 checkOutput("fault half 0x21", 32'(faultV[1]), 32'h1);
    load("mem0 intact 64", 1, 32'h00, 2'd2, 1'b0, 32'h12345678);
    load("mem0 intact 8", 0, 32'h00, 2'd2, 1'b0, 32'h12345678);
    load("word 0x20 intact", 1, 32'h20, 2'd2, 1'b0, 32'h0);

    idle();
    doReset();
    #1 checkOutput("seen cleared", 32'(seenV), 32'h0);
    countBusy(1, 100, n);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/dmem_sized.md
# dmem_sized

Parametrised data memory for the single-cycle ARM datapath. It replaces the fixed 8-word, word-only data memory with:

- configurable depth;
- ARM byte, halfword and word loads and stores, with zero or sign extension on loads;
- alignment and range fault detection;
- a reset-driven clear sequencer that zeroes the array before the core may use it.

## Interface

Parameters:
- DEPTH, 64: number of 32-bit words; power of two, 8 to 4096. AW = log2(DEPTH).
- CLEAR_ON_RESET, 1: 1 = sweep the array to zero after reset; 0 = skip the sweep and leave contents unchanged.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  32  byte address from the ALU result.
- WD  input  32  store data; the low byte or low halfword is used for sub-word stores.
- WE  input  1  store enable.
- SIZE  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- SIGNED  input  1  load extension for byte and halfword loads: 1 = sign extend, 0 = zero extend.
- RD  output  32  load data, combinational.
- BUSY  output  1  clear sweep in progress; the core must stall.
- FAULT  output  1  combinational: the current access is misaligned, out of range or of reserved size.
- FAULT_SEEN  output  1  sticky fault flag; cleared only by reset.

## Operation

State machine:
- States are CLEAR and READY.
- rst_n low forces CLEAR (if CLEAR_ON_RESET=1) or READY (if 0), with ptr=0 and FAULT_SEEN=0.
- In CLEAR, each clk edge writes 0 to mem[ptr] and increments ptr.
- The edge that writes mem[DEPTH-1] moves the state to READY.
- BUSY=1 exactly while in CLEAR.

Address decode:
- Word index is A[AW+1:2].
- Out of range: A[31:AW+2] != 0.
- Misaligned: SIZE=01 with A[0]=1, or SIZE=10 with A[1:0] != 0.
- FAULT = READY & (out of range | misaligned | SIZE=11).
- FAULT is 0 during CLEAR.

Stores (only in READY with FAULT=0 and WE=1):
- Byte: lane A[1:0] receives WD[7:0]; other lanes are unchanged.
- Halfword: A[1]=0 writes bits [15:0], A[1]=1 writes bits [31:16], from WD[15:0].
- Word: the full WD is written.
- WE during CLEAR or with FAULT=1 is ignored; memory is unchanged.

Loads (combinational from A, SIZE, SIGNED and the array):
- Word: RD = mem[idx].
- Byte: the selected lane is placed in RD[7:0]. RD[31:8] is its bit 7 if SIGNED=1, else 0.
- Halfword: the selected half is placed in RD[15:0]. RD[31:16] is its bit 15 if SIGNED=1, else 0.
- RD = 0 while BUSY=1 or FAULT=1.

FAULT_SEEN is set on any clk edge where FAULT=1 (load or store); it stays set until rst_n goes low.

## Timing

- Reset values:
  - CLEAR_ON_RESET=1: BUSY=1, FAULT=0, FAULT_SEEN=0, RD=0.
  - CLEAR_ON_RESET=0: BUSY=0.
- Clear duration: BUSY falls after exactly DEPTH rising edges following rst_n release.
- rst_n asserted mid-sweep restarts the sweep at ptr=0 after release.
- Stores take effect at the rising edge. RD reflects the new value from that edge onward.
- A load and a store to the same word in the same cycle: RD shows the old contents until the edge.
- Read latency is zero cycles (combinational), as required by the single-cycle core.
- ptr is AW+1 bits wide and never wraps past DEPTH-1 while in CLEAR.

## Test plan

- Reset sweep, DEPTH=8, CLEAR_ON_RESET=1, memory preloaded with nonzero data:
  - BUSY stays high for 8 edges after rst_n rises.
  - A word load from each of addresses 0x00 to 0x1C then returns 0.
- Reset mid-sweep: assert rst_n low for 1 cycle at sweep edge 3 -> BUSY stays high for 8 further edges.
- Byte lanes:
  - Store word 0x11223344 at 0x10, then store byte 0xAA (WD=0x000000AA) at 0x12.
  - Word load at 0x10 -> 0x11AA3344.
  - Signed byte load at 0x12 -> 0xFFFFFFAA.
  - Unsigned byte load at 0x12 -> 0x000000AA.
- Halfword:
  - Store half WD=0x00008001 at 0x16.
  - Signed half load at 0x16 -> 0xFFFF8001.
  - Unsigned half load at 0x16 -> 0x00008001.
  - Word load at 0x14 -> 0x8001xxxx, with the low half unchanged.
- Faults, DEPTH=64:
  - Word store at 0x102 (misaligned) -> FAULT=1, no write, FAULT_SEEN=1 after the edge.
  - Store at 0x100 (out of range) -> FAULT=1, mem[0] unchanged.
  - SIZE=11 -> FAULT=1.
- Access during BUSY: WE=1 to 0x04 while BUSY=1 -> RD=0, FAULT=0, and mem[1]=0 after the sweep completes.
